rgbw_pwm_engine: RTL
====================

Name: rgbw_pwm_engine

Overview:
- Four-channel (R, G, B, W) PWM generator. It is the stage directly downstream of the SPI deserializer / data dispenser.
- It accepts 8-bit duty values with a load strobe, holds them in a shadow bank and commits them to the active bank only at a PWM period boundary, so no output ever sees a glitched period.
- A run/stop FSM with a graceful drain and a programmable tick prescaler drive the LED power pins.

Parameters:
- DUTY_W, 8: duty and period-counter width. Period = 2^DUTY_W-1 ticks (255).
- PRESC_W, 8: prescaler divide-select width.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: run request (level).
- presc_div, input, PRESC_W: tick every presc_div+1 clk cycles.
- load, input, 1: one-cycle strobe; captures the four duty inputs.
- duty_r / duty_g / duty_b / duty_w, input, DUTY_W each: requested duty.
- pwm_r / pwm_g / pwm_b / pwm_w, output, 1 each: registered PWM outputs.
- period_start, output, 1: one-cycle pulse at the start of each period.
- pending, output, 1: shadow bank holds values not yet committed.
- running, output, 1: high in RUN or DRAIN.

Behaviour:
- Reset (synchronous, active-high) clears: presc_cnt=0, cnt=0, shadow and active banks=0, pending=0, FSM=OFF, all pwm_*=0, period_start=0, running=0.
- Prescaler:
  - presc_cnt counts only outside OFF.
  - tick=1 when presc_cnt==presc_div; presc_cnt then returns to 0.
  - presc_div=0 gives a tick every cycle.
  - A presc_div change takes effect at the next compare; it is not glitch-protected.
- Period counter: advances on tick, counts 0..254, then wraps to 0 ("wrap" = tick while cnt==254).
- Shadow capture:
  - load=1 in any state, including OFF: shadow<=duty_*, pending<=1.
  - A second load before commit overwrites the shadow; last load wins.
- Commit:
  - At wrap, or on the OFF->RUN transition, if pending=1: active<=shadow, pending<=0.
  - If load coincides with a commit, the committed value is the old shadow, the new values go to the shadow, and pending stays 1 (applied at the next wrap).
- Output:
  - pwm_x <= (state!=OFF) && (cnt < active_x), registered, one-cycle latency from cnt/active.
  - duty 0: constant low. duty 255: constant high across a full period.
- FSM states:
  - OFF: counters held at 0, outputs low.
    - enable=1 -> RUN: commits pending, clears cnt/presc_cnt, period_start=1 in the transition cycle.
  - RUN: period_start pulses on every wrap, registered, concurrent with cnt going to 0.
    - enable=0 -> DRAIN.
  - DRAIN: behaves like RUN until the next wrap, then -> OFF with outputs forced low the following cycle.
    - enable=1 in DRAIN -> RUN with no counter reset and no extra period_start.
- Simultaneous enable=0 and wrap in RUN: go to DRAIN. The current period has just completed, so DRAIN lasts a full new period. This is intentional: it keeps the last period whole.
- reset mid-period: all outputs low on the next edge. The shadow contents are lost.
- running = (state==RUN || state==DRAIN).

Test Plan:
- Reset then enable=1, presc_div=0, no load -> period_start pulse, all pwm_*=0 for 255 cycles, pending=0.
- load duty_r=0x40, duty_g=0x00, duty_b=0xFF, duty_w=0x80 while OFF; then enable -> pending=1, then 0 on entry. Per 255-cycle period: pwm_r high 64 cycles, pwm_g never high, pwm_b always high, pwm_w high 128 cycles.
- Mid-period load of duty_r=0x10 while duty_r active=0x40 -> current period keeps 64 high cycles, pending=1; the next period has 16 high cycles and pending=0 at the wrap.
- load asserted exactly on the wrap cycle with shadow pending=0x20 and new value 0x30 -> next period uses 0x20, pending stays 1, the following period uses 0x30.
- presc_div=3, duty_w=0x02 -> period_start spacing 1020 clk, pwm_w high for 8 clk per period.
- Deassert enable at cnt=100 -> outputs continue to wrap, then all low, running=0, state OFF. A repeat test re-asserts enable at cnt=200 in DRAIN -> no reset of cnt, no extra period_start. Reset asserted at cnt=50 -> outputs 0 on the next cycle and pending=0.

Source files
------------

// File: rtl/rgbw_pwm_engine.sv
// Four-channel RGBW PWM generator with a shadow/active duty bank, a tick
// prescaler and a run/drain/off sequencer that only changes duty at period edges.
module rgbw_pwm_engine #(
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               load,
  input  logic [DUTY_W-1:0]  duty_r,
  input  logic [DUTY_W-1:0]  duty_g,
  input  logic [DUTY_W-1:0]  duty_b,
  input  logic [DUTY_W-1:0]  duty_w,
  output logic               pwm_r,
  output logic               pwm_g,
  output logic               pwm_b,
  output logic               pwm_w,
  output logic               period_start,
  output logic               pending,
  output logic               running
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Last counter value of a period: the period is 2^DUTY_W-1 ticks long.
  localparam logic [DUTY_W-1:0] CNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};

  state_t                   state_q, state_d;
  logic [PRESC_W-1:0]       presc_cnt_q, presc_cnt_d;
  logic [DUTY_W-1:0]        cnt_q, cnt_d;
  logic [3:0][DUTY_W-1:0]   shadow_q, shadow_d;
  logic [3:0][DUTY_W-1:0]   active_q, active_d;
  logic [3:0][DUTY_W-1:0]   duty_in;
  logic                     pending_q, pending_d;
  logic                     period_start_q, period_start_d;
  logic [3:0]               pwm_q, pwm_d;
  logic                     tick;
  logic                     wrap;
  logic                     commit;

  assign duty_in = {duty_w, duty_b, duty_g, duty_r};
  assign tick    = (state_q != ST_OFF) && (presc_cnt_q == presc_div);
  assign wrap    = tick && (cnt_q == CNT_LAST);

  always_comb begin
    state_d        = state_q;
    presc_cnt_d    = presc_cnt_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    pending_d      = pending_q;
    period_start_d = 1'b0;
    commit         = 1'b0;

    if (state_q == ST_OFF) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      if (enable) begin
        state_d        = ST_RUN;
        commit         = 1'b1;
        period_start_d = 1'b1;
      end
    end else begin
      if (tick) begin
        presc_cnt_d = '0;
        cnt_d       = wrap ? '0 : cnt_q + DUTY_W'(1);
      end else begin
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
      end

      if (state_q == ST_RUN) begin
        if (!enable) state_d = ST_DRAIN;
      end else if (enable) begin
        state_d = ST_RUN;
      end else if (wrap) begin
        state_d = ST_OFF;
      end

      commit = wrap;
      // A wrap that ends the drain opens no new period, so it gets no pulse.
      period_start_d = wrap && (state_d != ST_OFF);
    end

    if (commit && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // A load in the commit cycle lands after the commit reads the old shadow.
    if (load) begin
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pwm
      assign pwm_d[gi] = (state_q != ST_OFF) && (cnt_q < active_q[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_OFF;
      presc_cnt_q    <= '0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      period_start_q <= 1'b0;
      pwm_q          <= '0;
    end else begin
      state_q        <= state_d;
      presc_cnt_q    <= presc_cnt_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      period_start_q <= period_start_d;
      pwm_q          <= pwm_d;
    end
  end

  assign pwm_r        = pwm_q[0];
  assign pwm_g        = pwm_q[1];
  assign pwm_b        = pwm_q[2];
  assign pwm_w        = pwm_q[3];
  assign period_start = period_start_q;
  assign pending      = pending_q;
  assign running      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule
